// File: rtl/result_queues_stage.sv
// Per-source result FIFOs arbitrated onto a single VRF write port with a REQ/GNT handshake.
// Optional ARA_WB_LOAD_PRIO_EN: load-unit queue (index 2) wins whenever non-empty.
module result_queues_stage #(
    parameter int unsigned NrSrc     = 4,
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned IdWidth   = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrSrc-1:0][AddrWidth-1:0]       res_addr_i,
    input  logic [NrSrc-1:0][DataWidth-1:0]       res_data_i,
    input  logic [NrSrc-1:0][DataWidth/8-1:0]     res_be_i,
    input  logic [NrSrc-1:0][IdWidth-1:0]         res_id_i,
    input  logic [NrSrc-1:0]                      res_valid_i,
    output logic [NrSrc-1:0]                      res_ready_o,
    output logic                                  vrf_req_o,
    output logic [AddrWidth-1:0]                  vrf_addr_o,
    output logic [DataWidth-1:0]                  vrf_wdata_o,
    output logic [DataWidth/8-1:0]                vrf_be_o,
    input  logic                                  vrf_gnt_i,
    output logic [NrSrc-1:0]                      wb_done_o,
    output logic [IdWidth-1:0]                    wb_done_id_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW    = $clog2(Depth + 1);
    localparam int unsigned SrcW    = (NrSrc > 1) ? $clog2(NrSrc) : 1;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [SrcW-1:0]   winner_q, winner_d;
    logic [SrcW-1:0]   rr_q, rr_d;

    logic [AddrWidth-1:0] addr_q [NrSrc][Depth];
    logic [DataWidth-1:0] data_q [NrSrc][Depth];
    logic [BeWidth-1:0]   be_q   [NrSrc][Depth];
    logic [IdWidth-1:0]   id_q   [NrSrc][Depth];

    logic [PtrW-1:0] wr_ptr_q [NrSrc];
    logic [PtrW-1:0] wr_ptr_d [NrSrc];
    logic [PtrW-1:0] rd_ptr_q [NrSrc];
    logic [PtrW-1:0] rd_ptr_d [NrSrc];
    logic [CntW-1:0] count_q  [NrSrc];
    logic [CntW-1:0] count_d  [NrSrc];

    logic [NrSrc-1:0] push, pop, avail;
    logic             grant;
    logic             sel_found;
    logic [SrcW-1:0]  sel_idx, cand;

    // A reset cycle never commits, even if the bank grants.
    assign grant = (state_q == StReq) && vrf_gnt_i && !rst_i;

    always_comb begin
        for (int i = 0; i < NrSrc; i++) begin
            res_ready_o[i] = count_q[i] < CntW'(Depth);
            push[i]        = res_valid_i[i] && res_ready_o[i];
            pop[i]         = grant && (winner_q == SrcW'(i));
            count_d[i]     = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            avail[i]       = count_d[i] != '0;
            wr_ptr_d[i]    = wr_ptr_q[i];
            rd_ptr_d[i]    = rd_ptr_q[i];
            if (push[i]) begin
                wr_ptr_d[i] = (wr_ptr_q[i] == PtrW'(Depth - 1)) ? '0 : wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == PtrW'(Depth - 1)) ? '0 : rd_ptr_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_d      = rr_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
`ifdef ARA_WB_LOAD_PRIO_EN
        if (grant && (winner_q != SrcW'(2))) begin
            rr_d = (winner_q == SrcW'(NrSrc - 1)) ? '0 : winner_q + 1'b1;
        end
`else
        if (grant) begin
            rr_d = (winner_q == SrcW'(NrSrc - 1)) ? '0 : winner_q + 1'b1;
        end
`endif
        // Availability already accounts for this cycle's push and pop.
        for (int k = 0; k < NrSrc; k++) begin
            cand = SrcW'((int'(rr_d) + k) % NrSrc);
            if (!sel_found && avail[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef ARA_WB_LOAD_PRIO_EN
        if (avail[2]) begin
            sel_found = 1'b1;
            sel_idx   = SrcW'(2);
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d  = StReq;
                    winner_d = sel_idx;
                end
            end
            StReq: begin
                if (grant) begin
                    if (sel_found) winner_d = sel_idx;
                    else           state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign vrf_req_o    = (state_q == StReq);
    assign vrf_addr_o   = addr_q[winner_q][rd_ptr_q[winner_q]];
    assign vrf_wdata_o  = data_q[winner_q][rd_ptr_q[winner_q]];
    assign vrf_be_o     = be_q[winner_q][rd_ptr_q[winner_q]];
    assign wb_done_o    = grant ? (NrSrc'(1) << winner_q) : '0;
    assign wb_done_id_o = grant ? id_q[winner_q][rd_ptr_q[winner_q]] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            winner_q <= '0;
            rr_q     <= '0;
            for (int i = 0; i < NrSrc; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_q     <= rr_d;
            for (int i = 0; i < NrSrc; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrSrc; i++) begin
            if (push[i] && !rst_i) begin
                addr_q[i][wr_ptr_q[i]] <= res_addr_i[i];
                data_q[i][wr_ptr_q[i]] <= res_data_i[i];
                be_q[i][wr_ptr_q[i]]   <= res_be_i[i];
                id_q[i][wr_ptr_q[i]]   <= res_id_i[i];
            end
        end
    end

endmodule
